// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side sram-like bus.
// Holds size codes, owner IDs and width helpers used by the arbiter and its owner FIFO.
// No logic of its own.
package cpu_bus_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // Pointer width for a circular buffer of n entries; at least one bit so depth 1 still has a pointer.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold the values 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner FIFO: a 1-bit tag records which master owns each outstanding transaction.
// Latency: head_o is valid combinationally from the stored entry; push/pop take effect at the next edge.
// Backpressure: full_o tells the arbiter to stop granting. A push while full is never issued.
module owner_fifo
   import cpu_bus_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next-state pointers and count. A simultaneous push and pop leaves the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (pop_i && !push_i) count_d = count_q - 1'b1;
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave between instruction (m0) and data (m1) masters, with in-order response routing.
// Latency: zero added cycles on address and data paths; state updates at the next edge.
// Backpressure: no grant while MAX_OUT transactions are outstanding; a losing master sees addr_ok=0 and holds.
module sram_like_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int unsigned MAX_OUT      = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_addr_ok,
   output logic        m0_data_ok,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_addr_ok,
   output logic        m1_data_ok,
   output logic        s_req,
   output logic        s_wr,
   output logic [1:0]  s_size,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_addr_ok,
   input  logic        s_data_ok,
   output logic        orphan_err
);

   localparam int unsigned SW = cnt_width(STARVE_LIMIT);

   logic          fifo_full, fifo_empty, fifo_head;
   logic          gnt0, gnt1, accept, pop;
   logic [SW-1:0] starve_q, starve_d;
   logic          orphan_q, orphan_d;

   // Data master wins ties unless the instruction master has waited through STARVE_LIMIT data grants.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!fifo_full) begin
         if (m0_req && m1_req) begin
            if (starve_q == SW'(STARVE_LIMIT)) gnt0 = 1'b1;
            else                               gnt1 = 1'b1;
         end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
         end
      end
   end

   // Forward the granted master's address phase; everything is zero when nobody is granted.
   always_comb begin
      s_req   = 1'b0;
      s_wr    = 1'b0;
      s_size  = 2'd0;
      s_addr  = 32'd0;
      s_wdata = 32'd0;
      if (gnt0) begin
         s_req   = 1'b1;
         s_wr    = m0_wr;
         s_size  = m0_size;
         s_addr  = m0_addr;
         s_wdata = m0_wdata;
      end else if (gnt1) begin
         s_req   = 1'b1;
         s_wr    = m1_wr;
         s_size  = m1_size;
         s_addr  = m1_addr;
         s_wdata = m1_wdata;
      end
   end

   assign accept     = s_req & s_addr_ok;
   assign m0_addr_ok = gnt0 & s_addr_ok;
   assign m1_addr_ok = gnt1 & s_addr_ok;

   // A response with nothing outstanding is dropped rather than popped.
   assign pop        = s_data_ok & ~fifo_empty;
   assign m0_data_ok = pop & (fifo_head == OWNER_INST);
   assign m1_data_ok = pop & (fifo_head == OWNER_DATA);
   assign m0_rdata   = m0_data_ok ? s_rdata : 32'd0;
   assign m1_rdata   = m1_data_ok ? s_rdata : 32'd0;

   owner_fifo #(
      .DEPTH (MAX_OUT)
   ) u_owner_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .push_i  (accept),
      .din_i   (gnt1 ? OWNER_DATA : OWNER_INST),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Starvation counter tracks consecutive data grants taken while fetch was waiting; orphan flag is sticky.
   always_comb begin
      starve_d = starve_q;
      if (!m0_req || (accept && gnt0)) starve_d = '0;
      else if (accept && gnt1 && (starve_q != SW'(STARVE_LIMIT))) starve_d = starve_q + 1'b1;
      orphan_d = orphan_q | (s_data_ok & fifo_empty);
   end

   // Arbitration state register with synchronous reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         starve_q <= '0;
         orphan_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         orphan_q <= orphan_d;
      end
   end

   assign orphan_err = orphan_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed bench for sram_like_arbiter against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared 1ns later, before the rising edge.
// Model state advances on each rising edge from the inputs applied during that cycle.
module tb_sram_like_arbiter;

   localparam int MAX_OUT = 2;
   localparam int SL      = 4;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
   logic        s_req, s_wr;
   logic [1:0]  s_size;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        s_addr_ok, s_data_ok;
   logic        orphan_err;

   always #5 aclk = ~aclk;

   sram_like_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(SL)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
      .orphan_err(orphan_err)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: owners of outstanding transactions in order, starvation count, sticky orphan flag.
   int owner_q[$];
   int starve_m = 0;
   bit orphan_m = 1'b0;
   bit acc0, acc1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: predict and compare all outputs, then advance the model at the rising edge.
   task automatic step();
      int          g;
      int          head;
      bit          resp;
      logic        e_wr;
      logic [1:0]  e_size;
      logic [31:0] e_addr, e_wdata;
      #1;
      if (owner_q.size() >= MAX_OUT)  g = -1;
      else if (m0_req && m1_req)      g = (starve_m == SL) ? 0 : 1;
      else if (m0_req)                g = 0;
      else if (m1_req)                g = 1;
      else                            g = -1;
      e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wdata = 32'd0;
      if (g == 0) begin e_wr = m0_wr; e_size = m0_size; e_addr = m0_addr; e_wdata = m0_wdata; end
      if (g == 1) begin e_wr = m1_wr; e_size = m1_size; e_addr = m1_addr; e_wdata = m1_wdata; end
      resp = s_data_ok && (owner_q.size() > 0);
      head = resp ? owner_q[0] : -1;

      chk("s_req",      32'(s_req),      32'(g >= 0));
      chk("s_wr",       32'(s_wr),       32'(e_wr));
      chk("s_size",     32'(s_size),     32'(e_size));
      chk("s_addr",     s_addr,          e_addr);
      chk("s_wdata",    s_wdata,         e_wdata);
      chk("m0_addr_ok", 32'(m0_addr_ok), 32'((g == 0) && s_addr_ok));
      chk("m1_addr_ok", 32'(m1_addr_ok), 32'((g == 1) && s_addr_ok));
      chk("m0_data_ok", 32'(m0_data_ok), 32'(head == 0));
      chk("m1_data_ok", 32'(m1_data_ok), 32'(head == 1));
      chk("m0_rdata",   m0_rdata,        (head == 0) ? s_rdata : 32'd0);
      chk("m1_rdata",   m1_rdata,        (head == 1) ? s_rdata : 32'd0);
      chk("orphan_err", 32'(orphan_err), 32'(orphan_m));

      acc0 = (g == 0) && s_addr_ok;
      acc1 = (g == 1) && s_addr_ok;
      @(posedge aclk);
      if (!aresetn) begin
         owner_q.delete();
         starve_m = 0;
         orphan_m = 1'b0;
         acc0 = 1'b0;
         acc1 = 1'b0;
      end else begin
         if (s_data_ok && owner_q.size() == 0) orphan_m = 1'b1;
         if (resp) void'(owner_q.pop_front());
         if (acc0) owner_q.push_back(0);
         if (acc1) owner_q.push_back(1);
         if (!m0_req || acc0)              starve_m = 0;
         else if (acc1 && starve_m < SL)   starve_m++;
      end
      @(negedge aclk);
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
      s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;
   endtask

   // Answer everything outstanding with no new requests.
   task automatic drain();
      m0_req = 0; m1_req = 0; s_addr_ok = 0; s_data_ok = 1;
      for (int i = 0; i < MAX_OUT + 1 && owner_q.size() > 0; i++) begin
         s_rdata = $urandom;
         step();
      end
      s_data_ok = 0;
   endtask

   int exp_g1[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   initial begin
      idle_inputs();
      aresetn = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      step();
      chk("rst_s_req", 32'(s_req), 32'd0);
      chk("rst_orphan", 32'(orphan_err), 32'd0);

      // Single fetch and its response.
      aresetn = 1;
      m0_req = 1; m0_addr = 32'hBFC00000; m0_size = 2'd2; s_addr_ok = 1;
      #1 chk("t1_addr_ok", 32'(m0_addr_ok), 32'd1);
      step();
      m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h3C080001;
      #1 chk("t1_data_ok", 32'(m0_data_ok), 32'd1);
      chk("t1_rdata", m0_rdata, 32'h3C080001);
      step();
      s_data_ok = 0;
      step();

      // Both masters held: data wins four times, then fetch is forced.
      m0_req = 1; m1_req = 1; m0_addr = 32'h1000; m1_addr = 32'h2000; s_addr_ok = 1;
      for (int i = 0; i < 10; i++) begin
         #1 chk("t2_gnt_m1", 32'(m1_addr_ok), 32'(exp_g1[i]));
         chk("t2_gnt_m0", 32'(m0_addr_ok), 32'(1 - exp_g1[i]));
         step();
         s_data_ok = 1;
         s_rdata = $urandom;
      end
      drain();

      // Outstanding limit blocks the third request until a response frees a slot.
      m0_req = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = 0;
      step();
      step();
      #1 chk("t3_full_s_req", 32'(s_req), 32'd0);
      s_data_ok = 1; s_rdata = 32'h55;
      step();
      s_data_ok = 0;
      #1 chk("t3_regrant", 32'(s_req), 32'd1);
      step();
      drain();

      // Responses routed in acceptance order.
      m0_req = 1; m1_req = 0; m0_addr = 32'h100; s_addr_ok = 1;
      step();
      m0_req = 0; m1_req = 1; m1_addr = 32'h200;
      #1 chk("t4_m1_addr", s_addr, 32'h200);
      step();
      m1_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hAAAA0000;
      #1 chk("t4_m0_rdata", m0_rdata, 32'hAAAA0000);
      chk("t4_m1_quiet", 32'(m1_data_ok), 32'd0);
      step();
      s_rdata = 32'hBBBB0000;
      #1 chk("t4_m1_rdata", m1_rdata, 32'hBBBB0000);
      chk("t4_m0_quiet", 32'(m0_data_ok), 32'd0);
      step();
      s_data_ok = 0;

      // Reset with two in flight: later responses are orphans.
      m0_req = 1; m1_req = 1; s_addr_ok = 1;
      step();
      step();
      m0_req = 0; m1_req = 0; s_addr_ok = 0;
      aresetn = 0;
      step();
      aresetn = 1; s_data_ok = 1; s_rdata = 32'hDEAD0001;
      #1 chk("t6_no_dok0", 32'(m0_data_ok), 32'd0);
      chk("t6_no_dok1", 32'(m1_data_ok), 32'd0);
      step();
      s_data_ok = 0;
      #1 chk("t6_orphan", 32'(orphan_err), 32'd1);
      step();

      // Random traffic: masters hold a request until it is accepted; occasional resets.
      aresetn = 0;
      step();
      acc0 = 1; acc1 = 1;
      for (int n = 0; n < 3000; n++) begin
         if (!m0_req || acc0) begin
            m0_req = ($urandom % 3) != 0; m0_wr = 0; m0_size = 2'($urandom % 3);
            m0_addr = $urandom; m0_wdata = $urandom;
         end
         if (!m1_req || acc1) begin
            m1_req = ($urandom % 3) != 0; m1_wr = 1'($urandom); m1_size = 2'($urandom % 3);
            m1_addr = $urandom; m1_wdata = $urandom;
         end
         s_addr_ok = ($urandom % 4) != 0;
         s_data_ok = ($urandom % 5) < 2;
         s_rdata   = $urandom;
         aresetn   = ($urandom % 80) != 0;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
